board_cell_counter: RTL and testbench

- Consumes the cleaned binary pixel stream (clean bit, valid, X/Y counters, frame enable) from the noise-removal stage.
- Counts foreground pixels in each of the 9 cells of a fixed 3x3 tic-tac-toe grid region once per frame, then thresholds each count into an occupancy bitmap for the game logic.
- Latched per-cell counts are readable through a registered select port for debug and calibration.

---
 rtl/ipu_pkg.sv | 15 +
 rtl/grid_cell_map.sv | 65 ++++++
 rtl/board_cell_counter.sv | 168 ++++++++++++++++
 tb/tb_board_cell_counter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipu_pkg.sv
// Shared constants and types for the image-processing pipeline stages.
package ipu_pkg;

  localparam int unsigned IMG_W_DEF  = 640;
  localparam int unsigned IMG_H_DEF  = 480;
  localparam int unsigned CELL_IDX_W = 4;
  localparam int unsigned NUM_CELLS  = 9;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } cell_fsm_e;

endpackage

// File: rtl/grid_cell_map.sv
// Maps a pixel coordinate onto the 3x3 board grid: in-grid flag and
// row-major cell index. Pure comparators against elaboration constants.
module grid_cell_map
  import ipu_pkg::*;
#(
  parameter int unsigned GRID_X0 = 160,
  parameter int unsigned GRID_Y0 = 80,
  parameter int unsigned CELL_W  = 100,
  parameter int unsigned CELL_H  = 100
) (
  input  logic [15:0]           x_i,
  input  logic [15:0]           y_i,
  output logic                  in_grid_c_o,
  output logic [CELL_IDX_W-1:0] cell_idx_c_o
);

  localparam int unsigned X1 = GRID_X0 + CELL_W;
  localparam int unsigned X2 = GRID_X0 + 2 * CELL_W;
  localparam int unsigned X3 = GRID_X0 + 3 * CELL_W;
  localparam int unsigned Y1 = GRID_Y0 + CELL_H;
  localparam int unsigned Y2 = GRID_Y0 + 2 * CELL_H;
  localparam int unsigned Y3 = GRID_Y0 + 3 * CELL_H;

  logic [31:0] x_w;
  logic [31:0] y_w;
  logic [1:0]  col_c;
  logic [1:0]  row_c;
  logic        col_ok_c;
  logic        row_ok_c;

  assign x_w = 32'(x_i);
  assign y_w = 32'(y_i);

  always_comb begin
    col_c    = 2'd0;
    col_ok_c = 1'b1;
    if (x_w >= GRID_X0 && x_w < X1) begin
      col_c = 2'd0;
    end else if (x_w >= X1 && x_w < X2) begin
      col_c = 2'd1;
    end else if (x_w >= X2 && x_w < X3) begin
      col_c = 2'd2;
    end else begin
      col_ok_c = 1'b0;
    end
  end

  always_comb begin
    row_c    = 2'd0;
    row_ok_c = 1'b1;
    if (y_w >= GRID_Y0 && y_w < Y1) begin
      row_c = 2'd0;
    end else if (y_w >= Y1 && y_w < Y2) begin
      row_c = 2'd1;
    end else if (y_w >= Y2 && y_w < Y3) begin
      row_c = 2'd2;
    end else begin
      row_ok_c = 1'b0;
    end
  end

  assign in_grid_c_o  = col_ok_c & row_ok_c;
  assign cell_idx_c_o = CELL_IDX_W'(({2'b00, row_c} * 4'd3) + {2'b00, col_c});

endmodule

// File: rtl/board_cell_counter.sv
// Per-frame foreground pixel counts for the 9 board cells, thresholded into
// an occupancy bitmap; latched counts are readable through a select port.
module board_cell_counter
  import ipu_pkg::*;
#(
  parameter int unsigned IMG_W      = IMG_W_DEF,
  parameter int unsigned IMG_H      = IMG_H_DEF,
  parameter int unsigned GRID_X0    = 160,
  parameter int unsigned GRID_Y0    = 80,
  parameter int unsigned CELL_W     = 100,
  parameter int unsigned CELL_H     = 100,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned OCC_THRESH = 1500
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  input  logic                 iDCLEAN,
  input  logic                 iDVAL,
  input  logic [15:0]          iX_Cont,
  input  logic [15:0]          iY_Cont,
  input  logic                 iFrame_En,
  input  logic [3:0]           iCellSel,
  output logic [NUM_CELLS-1:0] oOccupied,
  output logic                 oFrameDone,
  output logic [CNT_W-1:0]     oCellCount,
  output logic                 oBusy
);

  if ((OCC_THRESH >> CNT_W) != 0) begin : g_thresh_check
    $error("board_cell_counter: OCC_THRESH must be below 2**CNT_W");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] THRESH  = CNT_W'(OCC_THRESH);

  cell_fsm_e            state_q, state_d;
  logic [CNT_W-1:0]     acc_q [NUM_CELLS];
  logic [CNT_W-1:0]     acc_d [NUM_CELLS];
  logic [CNT_W-1:0]     lat_q [NUM_CELLS];
  logic [CNT_W-1:0]     lat_d [NUM_CELLS];
  logic [NUM_CELLS-1:0] occ_q, occ_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;
  logic [CNT_W-1:0]     rd_q, rd_d;

  logic                  in_grid_c;
  logic [CELL_IDX_W-1:0] cell_idx_c;
  logic                  start_c;
  logic                  last_c;
  logic                  restart_c;
  logic                  count_c;

  grid_cell_map #(
    .GRID_X0 (GRID_X0),
    .GRID_Y0 (GRID_Y0),
    .CELL_W  (CELL_W),
    .CELL_H  (CELL_H)
  ) u_map (
    .x_i          (iX_Cont),
    .y_i          (iY_Cont),
    .in_grid_c_o  (in_grid_c),
    .cell_idx_c_o (cell_idx_c)
  );

  assign start_c = iDVAL && (iX_Cont == 16'd0) && (iY_Cont == 16'd0);
  assign last_c  = iDVAL && (32'(iX_Cont) == IMG_W - 32'd1)
                         && (32'(iY_Cont) == IMG_H - 32'd1);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    lat_d     = lat_q;
    occ_d     = occ_q;
    done_d    = 1'b0;
    busy_d    = busy_q;
    rd_d      = '0;
    restart_c = 1'b0;
    count_c   = 1'b0;

    unique case (state_q)
      IDLE, PUBLISH: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        if (start_c && iFrame_En) begin
          restart_c = 1'b1;
        end
      end
      ACCUM: begin
        if (start_c) begin
          // Truncated frame: drop what we have, re-arm only if enabled.
          state_d   = IDLE;
          busy_d    = 1'b0;
          restart_c = iFrame_En;
        end else if (iDVAL) begin
          count_c = 1'b1;
          if (last_c) begin
            state_d = PUBLISH;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (restart_c) begin
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
        acc_d[k] = '0;
      end
      count_c = 1'b1;
      state_d = ACCUM;
      busy_d  = 1'b1;
    end

    if (count_c && iDCLEAN && in_grid_c) begin
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
        if (cell_idx_c == CELL_IDX_W'(k) && acc_d[k] != CNT_MAX) begin
          acc_d[k] = acc_d[k] + CNT_W'(1);
        end
      end
    end

    // Publish includes the last pixel so results appear one cycle after it.
    if (done_d) begin
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
        lat_d[k] = acc_d[k];
        occ_d[k] = (acc_d[k] >= THRESH);
      end
    end

    for (int unsigned k = 0; k < NUM_CELLS; k++) begin
      if (iCellSel == 4'(k)) begin
        rd_d = lat_q[k];
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q <= IDLE;
      for (int unsigned k = 0; k < NUM_CELLS; k++) begin
        acc_q[k] <= '0;
        lat_q[k] <= '0;
      end
      occ_q  <= '0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
      rd_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      lat_q   <= lat_d;
      occ_q   <= occ_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
    end
  end

  assign oOccupied  = occ_q;
  assign oFrameDone = done_q;
  assign oCellCount = rd_q;
  assign oBusy      = busy_q;

endmodule

// File: tb/tb_board_cell_counter.sv
// Bench for board_cell_counter: directed frames plus randomized sparse pixel
// streams against an arithmetic per-cell counting model.
module tb_board_cell_counter;

  localparam int GX0    = 160;
  localparam int GY0    = 80;
  localparam int CW     = 100;
  localparam int CH     = 100;
  localparam int LAST_X = 639;
  localparam int LAST_Y = 479;

  logic        clk = 1'b0;
  logic        rst, dval, clean, en;
  logic [15:0] x, y;
  logic [3:0]  sel;
  logic [8:0]  occ0, occ1;
  logic        done0, done1, busy0, busy1;
  logic [15:0] cnt0;
  logic [7:0]  cnt1;

  always #5 clk = ~clk;

  board_cell_counter u_dut (
    .iCLK(clk), .iRST(rst), .iDCLEAN(clean), .iDVAL(dval),
    .iX_Cont(x), .iY_Cont(y), .iFrame_En(en), .iCellSel(sel),
    .oOccupied(occ0), .oFrameDone(done0), .oCellCount(cnt0), .oBusy(busy0)
  );

  board_cell_counter #(.CNT_W(8), .OCC_THRESH(200)) u_dut_sat (
    .iCLK(clk), .iRST(rst), .iDCLEAN(clean), .iDVAL(dval),
    .iX_Cont(x), .iY_Cont(y), .iFrame_En(en), .iCellSel(sel),
    .oOccupied(occ1), .oFrameDone(done1), .oCellCount(cnt1), .oBusy(busy1)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t got=%0d expected=%0d", tag, $time, got, exp);
    end
  endtask

  // Reference model: index 0 = default instance, 1 = 8-bit saturating one.
  bit          m_act, m_busy, m_done;
  int unsigned m_acc [2][9];
  int unsigned m_lat [2][9];
  int unsigned m_cnt [2];
  logic [8:0]  m_occ [2];

  function automatic int unsigned cap_of(input int m);
    return (m == 0) ? 65535 : 255;
  endfunction

  function automatic int unsigned thr_of(input int m);
    return (m == 0) ? 1500 : 200;
  endfunction

  function automatic int cell_of(input int xx, input int yy);
    if (xx < GX0 || xx >= GX0 + 3*CW || yy < GY0 || yy >= GY0 + 3*CH) return -1;
    return 3 * ((yy - GY0) / CH) + (xx - GX0) / CW;
  endfunction

  task automatic model_add(input bit c, input int xx, input int yy);
    int k;
    k = cell_of(xx, yy);
    if (c && k >= 0) begin
      for (int m = 0; m < 2; m++)
        if (m_acc[m][k] < cap_of(m)) m_acc[m][k]++;
    end
  endtask

  task automatic model_step(input bit r, input bit v, input bit c, input int xx, input int yy,
                            input bit e, input int s);
    int unsigned nxt [2];
    bit st, ls;
    for (int m = 0; m < 2; m++) nxt[m] = (s < 9) ? m_lat[m][s] : 0;
    if (r) begin
      m_act = 0; m_busy = 0; m_done = 0;
      for (int m = 0; m < 2; m++) begin
        m_occ[m] = '0; nxt[m] = 0;
        for (int k = 0; k < 9; k++) begin m_acc[m][k] = 0; m_lat[m][k] = 0; end
      end
    end else begin
      m_done = 0;
      st = v && xx == 0 && yy == 0;
      ls = v && xx == LAST_X && yy == LAST_Y;
      if (st) begin
        m_act = e; m_busy = e;
        if (e) begin
          for (int m = 0; m < 2; m++)
            for (int k = 0; k < 9; k++) m_acc[m][k] = 0;
          model_add(c, xx, yy);
        end
      end else if (m_act && v) begin
        model_add(c, xx, yy);
        if (ls) begin
          m_act = 0; m_busy = 0; m_done = 1;
          for (int m = 0; m < 2; m++)
            for (int k = 0; k < 9; k++) begin
              m_lat[m][k] = m_acc[m][k];
              m_occ[m][k] = (m_acc[m][k] >= thr_of(m));
            end
        end
      end
    end
    for (int m = 0; m < 2; m++) m_cnt[m] = nxt[m];
  endtask

  task automatic tick(input bit r, input bit v, input bit c, input int xx, input int yy, input bit e);
    rst = r; dval = v; clean = c; x = 16'(xx); y = 16'(yy); en = e;
    @(posedge clk);
    #1;
    model_step(r, v, c, xx, yy, e, int'(sel));
    check_eq("occ",      32'(occ0),  32'(m_occ[0]));
    check_eq("done",     32'(done0), 32'(m_done));
    check_eq("busy",     32'(busy0), 32'(m_busy));
    check_eq("cnt",      32'(cnt0),  m_cnt[0]);
    check_eq("sat_occ",  32'(occ1),  32'(m_occ[1]));
    check_eq("sat_done", 32'(done1), 32'(m_done));
    check_eq("sat_busy", 32'(busy1), 32'(m_busy));
    check_eq("sat_cnt",  32'(cnt1),  m_cnt[1]);
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 0, 0);
  endtask

  task automatic start_px(input bit e);
    tick(0, 1, 0, 0, 0, e);
  endtask

  task automatic last_px(input bit e);
    tick(0, 1, 0, LAST_X, LAST_Y, e);
  endtask

  task automatic fill(input int x0, input int y0, input int n, input bit e);
    for (int i = 0; i < n; i++) tick(0, 1, 1, x0 + i % CW, y0 + i / CW, e);
  endtask

  task automatic readback(input int s, input string tag, input int unsigned exp);
    sel = 4'(s);
    idle();
    check_eq(tag, 32'(cnt0), exp);
  endtask

  initial begin
    int hot, hx, hy, r;
    sel = 4'd0;
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 1, 1, 170, 90, 1);
    check_eq("rst_occ",  32'(occ0),  32'd0);
    check_eq("rst_busy", 32'(busy0), 32'd0);
    check_eq("rst_done", 32'(done0), 32'd0);
    check_eq("rst_cnt",  32'(cnt0),  32'd0);

    // Solid block in cell 0.
    start_px(1);
    check_eq("A_busy", 32'(busy0), 32'd1);
    fill(GX0, GY0, 10000, 1);
    last_px(1);
    check_eq("A_done", 32'(done0), 32'd1);
    check_eq("A_occ",  32'(occ0),  32'h001);
    idle();
    check_eq("A_done_pulse", 32'(done0), 32'd0);
    readback(0, "A_cnt0", 10000);
    readback(4, "A_cnt4", 0);

    // Grid boundaries.
    start_px(1);
    tick(0, 1, 1, 159, 100, 1);
    tick(0, 1, 1, 460, 100, 1);
    tick(0, 1, 1, 259, 80, 1);
    tick(0, 1, 1, 260, 80, 1);
    tick(0, 1, 1, 200, 79, 1);
    tick(0, 1, 1, 200, 380, 1);
    tick(0, 0, 1, 200, 100, 1);
    last_px(1);
    check_eq("B_occ", 32'(occ0), 32'd0);
    readback(0, "B_cnt0", 1);
    readback(1, "B_cnt1", 1);
    readback(2, "B_cnt2", 0);
    readback(3, "B_cnt3", 0);

    // Saturation in the 8-bit instance, cell 8.
    start_px(1);
    fill(360, 280, 300, 1);
    last_px(1);
    check_eq("D_sat_occ", 32'(occ1), 32'h100);
    check_eq("D_occ",     32'(occ0), 32'h000);
    sel = 4'd8;
    idle();
    check_eq("D_sat_cnt8", 32'(cnt1), 32'd255);
    check_eq("D_cnt8",     32'(cnt0), 32'd300);

    // Threshold edge in cell 4.
    start_px(1);
    fill(260, 180, 1499, 1);
    last_px(1);
    check_eq("C_occ_1499", 32'(occ0), 32'h000);
    start_px(1);
    fill(260, 180, 1500, 1);
    last_px(1);
    check_eq("C_occ_1500", 32'(occ0), 32'h010);

    // Disabled frame start: nothing happens, bitmap holds.
    start_px(0);
    check_eq("E_busy", 32'(busy0), 32'd0);
    fill(GX0, GY0, 1500, 1);
    last_px(1);
    check_eq("E_done", 32'(done0), 32'd0);
    check_eq("E_occ",  32'(occ0),  32'h010);

    // Enable dropped after start: still publishes.
    start_px(1);
    check_eq("F_busy", 32'(busy0), 32'd1);
    fill(GX0, GY0, 1500, 0);
    last_px(0);
    check_eq("F_done", 32'(done0), 32'd1);
    check_eq("F_occ",  32'(occ0),  32'h001);

    // Truncated frame restarts accumulation.
    start_px(1);
    fill(GX0, GY0, 200, 1);
    start_px(1);
    check_eq("G_no_done", 32'(done0), 32'd0);
    check_eq("G_busy",    32'(busy0), 32'd1);
    fill(GX0, GY0, 10, 1);
    last_px(1);
    check_eq("G_done", 32'(done0), 32'd1);
    check_eq("G_occ",  32'(occ0),  32'h000);
    readback(0, "G_cnt0", 10);

    // Reset in the middle of accumulation.
    start_px(1);
    fill(GX0, GY0, 5000, 1);
    tick(1, 1, 1, 170, 90, 1);
    check_eq("H_occ",  32'(occ0),  32'd0);
    check_eq("H_busy", 32'(busy0), 32'd0);
    check_eq("H_done", 32'(done0), 32'd0);
    check_eq("H_cnt",  32'(cnt0),  32'd0);
    start_px(1);
    fill(360, GY0, 20, 1);
    last_px(1);
    check_eq("H_done2", 32'(done0), 32'd1);
    readback(2, "H_cnt2", 20);

    // Randomized frames with a hot cell, restarts, gaps and rare resets.
    for (int f = 0; f < 12; f++) begin
      hot = $urandom_range(0, 8);
      hx  = GX0 + (hot % 3) * CW;
      hy  = GY0 + (hot / 3) * CH;
      sel = 4'($urandom_range(0, 15));
      tick(0, 1, 1'($urandom_range(0, 1)), 0, 0, $urandom_range(0, 7) != 0);
      for (int i = 0; i < 1000; i++) begin
        sel = 4'($urandom_range(0, 15));
        r   = $urandom_range(0, 399);
        if (r == 0)
          tick(1, 1'($urandom_range(0, 1)), 1, 0, 0, 1);
        else if (r < 4)
          tick(0, 1, 1'($urandom_range(0, 1)), 0, 0, 1'($urandom_range(0, 1)));
        else if (r < 40)
          tick(0, 0, 1'($urandom_range(0, 1)), $urandom_range(0, 639), $urandom_range(0, 479),
               1'($urandom_range(0, 1)));
        else if (r < 240)
          tick(0, 1, $urandom_range(0, 9) != 0, hx + $urandom_range(0, CW - 1),
               hy + $urandom_range(0, CH - 1), 1'($urandom_range(0, 1)));
        else if (r < 340)
          tick(0, 1, 1'($urandom_range(0, 1)), $urandom_range(155, 465), $urandom_range(75, 385),
               1'($urandom_range(0, 1)));
        else
          tick(0, 1, 1'($urandom_range(0, 1)), $urandom_range(0, 639), $urandom_range(0, 479),
               1'($urandom_range(0, 1)));
      end
      last_px(1'($urandom_range(0, 1)));
      sel = 4'($urandom_range(0, 15));
      idle();
      sel = 4'($urandom_range(0, 15));
      idle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
